hssl_reset_ctrl: RTL

Bring-up and recovery sequencer for the HSSL GTH transceiver. It drives the GTH reset-all, TX-datapath and RX-datapath resets in order, and waits on PLL lock and reset-done status with timeouts and bounded retries. It monitors the established link and restarts the RX path on loss of alignment. It sits between the transceiver wrapper and the HSSL virtual I/O: VIO reset requests come in, and state and retry status go back out as probes.

---
 rtl/hssl_ctrl_pkg.sv | 36 +++
 rtl/bit_synchronizer.sv | 25 ++
 rtl/hssl_reset_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hssl_ctrl_pkg.sv
// Shared types for the HSSL GTH reset sequencer: state encodings, widths and
// the grouped transceiver reset outputs.
package hssl_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RST_ALL  = 3'd0,
        ST_WAIT_PLL = 3'd1,
        ST_RST_TX   = 3'd2,
        ST_WAIT_TX  = 3'd3,
        ST_RST_RX   = 3'd4,
        ST_WAIT_RX  = 3'd5,
        ST_UP       = 3'd6,
        ST_FAIL     = 3'd7
    } state_e;

    typedef struct packed {
        logic all;
        logic tx;
        logic rx;
    } gt_rst_t;

    localparam gt_rst_t GT_RST_INIT = 3'b100;

    // Each GTH reset is asserted only while the sequencer sits in its pulse state.
    function automatic gt_rst_t gt_rst_decode(input state_e s);
        gt_rst_t r;
        r.all = (s == ST_RST_ALL);
        r.tx  = (s == ST_RST_TX);
        r.rx  = (s == ST_RST_RX);
        return r;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous status bit.
// Latency: STAGES cycles from input change to q.
// Backpressure: none, free-running.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hssl_reset_ctrl.sv
// GTH bring-up/recovery sequencer: reset-all, TX, RX pulses with lock/done waits.
// Latency: requests act 1 cycle after their rising edge; status inputs are seen 2 cycles late.
// Backpressure: none; timeouts and bounded retries end every wait, FAIL holds until req_all.
module hssl_reset_ctrl
    import hssl_ctrl_pkg::*;
#(
    parameter int PULSE_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int RETRY_MAX      = 3,
    parameter int LOSS_CYCLES    = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_all,
    input  logic               req_tx,
    input  logic               req_rx,
    input  logic               pll_lock,
    input  logic               tx_done,
    input  logic               rx_done,
    input  logic               rx_aligned,
    output logic               gt_reset_all,
    output logic               gt_reset_tx,
    output logic               gt_reset_rx,
    output logic               link_up,
    output logic               fail,
    output logic [STATE_W-1:0] state,
    output logic [RETRY_W-1:0] retries
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOSS_CYCLES + 1);

    localparam logic [TW-1:0]      T_MAX     = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]      P_LAST    = TW'(PULSE_CYCLES - 1);
    localparam logic [LW-1:0]      L_MAX     = LW'(LOSS_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

    state_e               state_q;
    state_e               state_nxt;
    logic [RETRY_W-1:0]   retries_q;
    logic [RETRY_W-1:0]   retries_nxt;
    logic [TW-1:0]        timer_q;
    logic [LW-1:0]        loss_q;
    logic [2:0]           req_q;
    gt_rst_t              gt_q;
    gt_rst_t              gt_nxt;
    logic                 link_up_nxt;
    logic                 fail_nxt;
    logic                 restart;
    logic                 enter;

    logic pll_lock_s;
    logic tx_done_s;
    logic rx_done_s;

    bit_synchronizer #(.STAGES(2)) u_sync_pll (.clk(clk), .rst(reset), .d(pll_lock), .q(pll_lock_s));
    bit_synchronizer #(.STAGES(2)) u_sync_tx  (.clk(clk), .rst(reset), .d(tx_done),  .q(tx_done_s));
    bit_synchronizer #(.STAGES(2)) u_sync_rx  (.clk(clk), .rst(reset), .d(rx_done),  .q(rx_done_s));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q <= '0;
        end else begin
            req_q <= {req_all, req_tx, req_rx};
        end
    end

    logic req_all_edge;
    logic req_tx_edge;
    logic req_rx_edge;
    logic path_req_ok;
    logic in_wait;
    logic pulse_done;
    logic timed_out;

    assign req_all_edge = req_all & ~req_q[2];
    assign req_tx_edge  = req_tx  & ~req_q[1];
    assign req_rx_edge  = req_rx  & ~req_q[0];

    // Path restarts make no sense before the PLL is up, and FAIL only leaves on req_all.
    assign path_req_ok = (state_q != ST_RST_ALL) && (state_q != ST_WAIT_PLL) && (state_q != ST_FAIL);
    assign in_wait     = (state_q == ST_WAIT_PLL) || (state_q == ST_WAIT_TX) || (state_q == ST_WAIT_RX);
    assign pulse_done  = (timer_q == P_LAST);
    assign timed_out   = (timer_q == T_MAX);

    // State and registered outputs; outputs follow the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RST_ALL;
            retries_q <= '0;
            gt_q      <= GT_RST_INIT;
            link_up   <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            retries_q <= retries_nxt;
            gt_q      <= gt_nxt;
            link_up   <= link_up_nxt;
            fail      <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        retries_nxt = retries_q;
        restart     = 1'b0;
        if (req_all_edge) begin
            state_nxt   = ST_RST_ALL;
            retries_nxt = '0;
            restart     = 1'b1;
        end else if (req_tx_edge && path_req_ok) begin
            state_nxt = ST_RST_TX;
            restart   = 1'b1;
        end else if (req_rx_edge && path_req_ok) begin
            state_nxt = ST_RST_RX;
            restart   = 1'b1;
        end else if (in_wait && timed_out) begin
            if (retries_q == RETRY_LIM) begin
                state_nxt = ST_FAIL;
            end else begin
                state_nxt   = ST_RST_ALL;
                retries_nxt = retries_q + 1'b1;
            end
        end else begin
            case (state_q)
                ST_RST_ALL:  if (pulse_done) state_nxt = ST_WAIT_PLL;
                ST_WAIT_PLL: if (pll_lock_s) state_nxt = ST_RST_TX;
                ST_RST_TX:   if (pulse_done) state_nxt = ST_WAIT_TX;
                ST_WAIT_TX:  if (tx_done_s)  state_nxt = ST_RST_RX;
                ST_RST_RX:   if (pulse_done) state_nxt = ST_WAIT_RX;
                ST_WAIT_RX: begin
                    if (rx_done_s && rx_aligned) begin
                        state_nxt   = ST_UP;
                        retries_nxt = '0;
                    end
                end
                ST_UP: begin
                    if (!pll_lock_s) begin
                        state_nxt = ST_RST_ALL;
                    end else if (loss_q == L_MAX) begin
                        state_nxt = ST_RST_RX;
                    end
                end
                ST_FAIL: state_nxt = ST_FAIL;
            endcase
        end
    end

    always_comb begin
        gt_nxt      = gt_rst_decode(state_nxt);
        link_up_nxt = (state_nxt == ST_UP);
        fail_nxt    = (state_nxt == ST_FAIL);
    end

    // A re-requested pulse state counts as a fresh entry so its pulse restarts.
    assign enter = restart || (state_nxt != state_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else if (enter) begin
            timer_q <= '0;
        end else if (timer_q != T_MAX) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loss_q <= '0;
        end else if ((state_q == ST_UP) && !rx_aligned) begin
            if (loss_q != L_MAX) begin
                loss_q <= loss_q + 1'b1;
            end
        end else begin
            loss_q <= '0;
        end
    end

    assign gt_reset_all = gt_q.all;
    assign gt_reset_tx  = gt_q.tx;
    assign gt_reset_rx  = gt_q.rx;
    assign state        = state_q;
    assign retries      = retries_q;

endmodule
